fnd_scan_drv: RTL and testbench
===============================

# fnd_scan_drv

Parametrised N-digit multiplexed seven-segment scan driver, the successor to the fixed six-digit display scanner. Takes pre-decoded segment patterns (a..g) per digit plus decimal points and per-digit blanking, double-buffers them with a load handshake applied only at frame boundaries (no tearing), and time-multiplexes them onto one shared segment bus with one-hot digit enables. Sits between the fnd decoders / counters and the board pins.

## Interface
- DIGITS, 6: number of digits scanned, 2..16.
- SCAN_DIV, 50000: clk cycles per digit slot; multiple of 16, >= 16.
- clk  in  1  system clock (50 MHz on board).
- rst_n  in  1  reset, asynchronous, active-low.
- i_seg  in  7*DIGITS  segment patterns, digit k in [7k+6:7k], bit order {a..g}, 1 = lit.
- i_dp  in  DIGITS  decimal point per digit, 1 = lit.
- i_blank  in  DIGITS  1 = digit k dark for whole slot.
- i_load  in  1  single-cycle strobe: capture i_seg/i_dp/i_blank into shadow buffer.
- i_bright  in  4  brightness level 0..15 (used only with FND_SCAN_BRIGHT_EN).
- o_busy  out  1  shadow holds data not yet applied to display buffer.
- o_frame  out  1  one-cycle pulse at each frame start (digit 0 slot begins).
- o_seg  out  7  shared segment bus, 1 = lit.
- o_seg_dp  out  1  shared decimal point, 1 = lit.
- o_seg_enb  out  DIGITS  digit common enables, active-low, at most one low.

## Operation
- Reset values: div counter 0, digit index 0, shadow/display buffers all 0 (blank bits 0), o_busy 0, o_frame 0, o_seg 0, o_seg_dp 0, o_seg_enb all 1.
- Prescaler div counts 0..SCAN_DIV-1 and wraps; on wrap digit index increments, DIGITS-1 wraps to 0.
- Frame boundary = cycle where div==SCAN_DIV-1 and index==DIGITS-1.
- Load: i_load captures inputs into shadow, sets pending (o_busy=1). Further i_load while pending overwrites shadow; only latest data is shown.
- At frame boundary, if pending: display buffer <= shadow, pending cleared. If i_load coincides with boundary: old shadow is applied, new data captured, pending stays 1.
- Slot drive for digit k: o_seg = disp_seg[k], o_seg_dp = disp_dp[k], o_seg_enb bit k low when enabled, all others high.
- Blanked digit: o_seg_enb all 1 for its slot; o_seg/o_seg_dp forced 0.
- Sub-phase = div / (SCAN_DIV/16), range 0..15.

## Timing
- All outputs registered; outputs in cycle t+1 reflect div/index/buffers in cycle t.
- o_frame high for exactly one cycle, the cycle after the frame boundary; asserted every frame regardless of pending.
- Load-to-display latency: between 1 and DIGITS*SCAN_DIV+1 cycles; o_busy falls in the cycle after the boundary that applies the data, same cycle o_frame rises.
- o_busy rises the cycle after i_load.
- Slot length exactly SCAN_DIV cycles; frame length DIGITS*SCAN_DIV cycles.
- o_seg, o_seg_dp and o_seg_enb change in the same cycle (no cross-digit ghost cycle).
- Reset mid-operation: all state returns to reset values immediately; pending load discarded.

## Configuration
- FND_SCAN_BRIGHT_EN defined: i_bright sampled at slot start (div==0) and held for the slot; enable low only while sub-phase <= sampled level (level 0 = 1/16 duty, 15 = full slot); o_seg/o_seg_dp forced 0 while enable inactive.
- Undefined: i_bright ignored, enable low for the full slot of every non-blanked digit.

## Test plan
- DIGITS=6, SCAN_DIV=16, reset then no load -> o_seg_enb cycles 111110,111101,...,011111, 16 cycles each; o_seg=0; o_frame every 96 cycles.
- i_load with digit k pattern = decoder code of k, i_dp=6'b000100 -> after next o_frame, slot k shows its pattern, o_seg_dp=1 only in slot 2; o_busy high from load+1 to boundary+1.
- Two i_load strobes within one frame (values A then B) -> only B displayed, never A; single busy fall.
- i_load on the exact boundary cycle -> previous shadow applied, new data displayed one frame later, o_busy stays 1 across boundary.
- i_blank=6'b100001 -> slots 0 and 5 keep o_seg_enb all 1 and o_seg=0; other slots unaffected.
- With FND_SCAN_BRIGHT_EN, i_bright=3 -> enable low 4 of 16 cycles per slot (div 0..3); i_bright=15 -> 16 of 16; assert rst_n low mid-slot -> all enables 1 next cycle.

Source files
------------

// File: rtl/fnd_scan_drv.sv
// Multiplexed N-digit seven-segment scan driver; new frame data swaps in at frame boundaries only.
// Latency: all outputs registered, one cycle behind the scan state; load-to-display is up to one frame.
// Backpressure: none; a new i_load overwrites pending data. FND_SCAN_BRIGHT_EN adds PWM brightness.
module fnd_scan_drv #(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7*DIGITS-1:0]   i_seg,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blank,
  input  logic                  i_load,
  input  logic [3:0]            i_bright,
  output logic                  o_busy,
  output logic                  o_frame,
  output logic [6:0]            o_seg,
  output logic                  o_seg_dp,
  output logic [DIGITS-1:0]     o_seg_enb
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    div_wrap;
  logic                    frame_end;

  logic [DIGITS-1:0][6:0]  sh_seg_q, sh_seg_d;
  logic [DIGITS-1:0]       sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]       sh_blank_q, sh_blank_d;
  logic [DIGITS-1:0][6:0]  disp_seg_q, disp_seg_d;
  logic [DIGITS-1:0]       disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]       disp_blank_q, disp_blank_d;
  logic                    pend_q, pend_d;

  logic                    slot_on;
  logic                    frame_q;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]       enb_q, enb_d;

  assign div_wrap  = (div_q == DIV_LAST);
  assign frame_end = div_wrap && (idx_q == IDX_LAST);

  always_comb begin
    div_d = div_wrap ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (div_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Apply before capture so a load on the boundary cycle leaves its own data pending.
  always_comb begin
    sh_seg_d     = sh_seg_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    disp_seg_d   = disp_seg_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_d       = pend_q;
    if (frame_end && pend_q) begin
      disp_seg_d   = sh_seg_q;
      disp_dp_d    = sh_dp_q;
      disp_blank_d = sh_blank_q;
      pend_d       = 1'b0;
    end
    if (i_load) begin
      sh_seg_d   = i_seg;
      sh_dp_d    = i_dp;
      sh_blank_d = i_blank;
      pend_d     = 1'b1;
    end
  end

`ifdef FND_SCAN_BRIGHT_EN
  localparam int SUB_LEN = SCAN_DIV / 16;
  localparam int SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_LEN - 1);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [3:0]       phase_q, phase_d;
  logic [3:0]       lvl_q, lvl_d;

  // phase_q tracks div / (SCAN_DIV/16) without a divider.
  always_comb begin
    sub_d   = sub_q;
    phase_d = phase_q;
    lvl_d   = lvl_q;
    if (div_wrap) begin
      sub_d   = '0;
      phase_d = '0;
    end else if (sub_q == SUB_LAST) begin
      sub_d   = '0;
      phase_d = phase_q + 1'b1;
    end else begin
      sub_d = sub_q + 1'b1;
    end
    if (div_q == '0) begin
      lvl_d = i_bright;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      phase_q <= '0;
      lvl_q   <= '0;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      lvl_q   <= lvl_d;
    end
  end
`else
  logic unused_bright;
  assign unused_bright = ^i_bright;
`endif

  // Phase 0 is always lit, so the level register is only consulted after it has loaded.
  always_comb begin
    slot_on = ~disp_blank_q[idx_q];
`ifdef FND_SCAN_BRIGHT_EN
    if (phase_q > lvl_q) begin
      slot_on = 1'b0;
    end
`endif
    seg_d    = '0;
    seg_dp_d = 1'b0;
    enb_d    = '1;
    if (slot_on) begin
      seg_d        = disp_seg_q[idx_q];
      seg_dp_d     = disp_dp_q[idx_q];
      enb_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      sh_seg_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      disp_seg_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_q       <= 1'b0;
      frame_q      <= 1'b0;
      seg_q        <= '0;
      seg_dp_q     <= 1'b0;
      enb_q        <= '1;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      sh_seg_q     <= sh_seg_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      disp_seg_q   <= disp_seg_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_q       <= pend_d;
      frame_q      <= frame_end;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      enb_q        <= enb_d;
    end
  end

  assign o_busy    = pend_q;
  assign o_frame   = frame_q;
  assign o_seg     = seg_q;
  assign o_seg_dp  = seg_dp_q;
  assign o_seg_enb = enb_q;

endmodule

// File: tb/tb_fnd_scan_drv.sv
// Bench for fnd_scan_drv: a cycle model pushes expected outputs each clock; scenario tasks pop and compare.
`timescale 1ns/1ps
module tb_fnd_scan_drv;
  localparam int DIGITS = 6;
  localparam int SD     = 16;
  localparam int FRAME  = DIGITS * SD;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7*DIGITS-1:0] i_seg = '0;
  logic [DIGITS-1:0]   i_dp = '0;
  logic [DIGITS-1:0]   i_blank = '0;
  logic                i_load = 1'b0;
  logic [3:0]          i_bright = 4'd15;
  logic                o_busy, o_frame, o_seg_dp;
  logic [6:0]          o_seg;
  logic [DIGITS-1:0]   o_seg_enb;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic              frame;
    logic              busy;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] enb;
  } out_t;

  out_t outs, e;
  out_t exp_q[$];
  assign outs = {o_frame, o_busy, o_seg, o_seg_dp, o_seg_enb};

  logic [6:0] dec [DIGITS] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B};

  fnd_scan_drv #(.DIGITS(DIGITS), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_dp(i_dp), .i_blank(i_blank),
    .i_load(i_load), .i_bright(i_bright), .o_busy(o_busy), .o_frame(o_frame),
    .o_seg(o_seg), .o_seg_dp(o_seg_dp), .o_seg_enb(o_seg_enb)
  );

  always #5 clk = ~clk;

  // Reference model: m_t is the position within the frame, 0..FRAME-1.
  int                m_t = 0;
  logic [6:0]        m_sh_seg [DIGITS] = '{default: '0};
  logic [6:0]        m_disp_seg [DIGITS] = '{default: '0};
  logic [DIGITS-1:0] m_sh_dp = '0, m_sh_blank = '0, m_disp_dp = '0, m_disp_blank = '0;
  logic              m_pend = 1'b0;
  logic [3:0]        m_lvl = '0;

  initial forever begin : model
    out_t x;
    int   d, k;
    logic on;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_t = 0; m_pend = 1'b0; m_lvl = '0;
      m_sh_dp = '0; m_sh_blank = '0; m_disp_dp = '0; m_disp_blank = '0;
      for (int i = 0; i < DIGITS; i++) begin m_sh_seg[i] = '0; m_disp_seg[i] = '0; end
      exp_q.delete();
    end else begin
      d  = m_t % SD;
      k  = m_t / SD;
      on = !m_disp_blank[k];
`ifdef FND_SCAN_BRIGHT_EN
      if (d / (SD / 16) > int'(m_lvl)) on = 1'b0;
`endif
      x.frame = (m_t == FRAME - 1);
      x.seg   = on ? m_disp_seg[k] : 7'd0;
      x.dp    = on & m_disp_dp[k];
      x.enb   = '1;
      if (on) x.enb[k] = 1'b0;
      if (m_t == FRAME - 1 && m_pend) begin
        for (int i = 0; i < DIGITS; i++) m_disp_seg[i] = m_sh_seg[i];
        m_disp_dp = m_sh_dp; m_disp_blank = m_sh_blank; m_pend = 1'b0;
      end
      if (i_load) begin
        for (int i = 0; i < DIGITS; i++) m_sh_seg[i] = i_seg[7*i +: 7];
        m_sh_dp = i_dp; m_sh_blank = i_blank; m_pend = 1'b1;
      end
      if (d == 0) m_lvl = i_bright;
      m_t    = (m_t + 1) % FRAME;
      x.busy = m_pend;
      exp_q.push_back(x);
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_seg_enb !== '1) begin errors++; $display("FAIL reset_enb: got %b want 111111", o_seg_enb); end
    checks++;
    if ({o_frame, o_busy, o_seg, o_seg_dp} !== 10'b0) begin
      errors++; $display("FAIL reset_outs: got %b want 0", {o_frame, o_busy, o_seg, o_seg_dp});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int frames = 0;
    logic [DIGITS-1:0] want;
    for (int n = 1; n <= 2 * FRAME; n++) begin
      cyc();
      checks++;
      if (outs !== e) begin errors++; $display("FAIL scan_model: n=%0d got %h want %h", n, outs, e); end
      want = ~(DIGITS'(1) << (((n - 1) / SD) % DIGITS));
      checks++;
      if (o_seg_enb !== want || o_seg !== 7'd0) begin
        errors++; $display("FAIL scan_slot: n=%0d enb %b seg %h want enb %b seg 00", n, o_seg_enb, o_seg, want);
      end
      if (o_frame) frames++;
    end
    checks++;
    if (frames != 2) begin errors++; $display("FAIL scan_frames: got %0d want 2", frames); end
  endtask

  task automatic test_load();
    bit fell = 0;
    cyc();
    checks++; if (outs !== e) begin errors++; $display("FAIL load_model: got %h want %h", outs, e); end
    for (int k = 0; k < DIGITS; k++) i_seg[7*k +: 7] = dec[k];
    i_dp = 6'b000100; i_blank = '0; i_load = 1'b1;
    cyc();
    i_load = 1'b0;
    checks++; if (outs !== e) begin errors++; $display("FAIL load_model: got %h want %h", outs, e); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL load_busy_rise: got %b want 1", o_busy); end
    for (int i = 0; i < FRAME + 2 && !fell; i++) begin
      cyc();
      checks++; if (outs !== e) begin errors++; $display("FAIL load_model: got %h want %h", outs, e); end
      if (o_busy === 1'b0) begin
        fell = 1;
        checks++; if (o_frame !== 1'b1) begin errors++; $display("FAIL load_busy_frame: frame %b want 1", o_frame); end
      end
    end
    checks++; if (!fell) begin errors++; $display("FAIL load_timeout: busy %b want 0", o_busy); end
    repeat (FRAME) begin
      cyc();
      checks++; if (outs !== e) begin errors++; $display("FAIL load_model: got %h want %h", outs, e); end
      for (int k = 0; k < DIGITS; k++) if (o_seg_enb[k] === 1'b0) begin
        checks++;
        if (o_seg !== dec[k] || o_seg_dp !== (k == 2)) begin
          errors++; $display("FAIL load_digit%0d: seg %h dp %b want seg %h dp %0d", k, o_seg, o_seg_dp, dec[k], k == 2);
        end
      end
    end
  endtask

  task automatic test_double_load();
    int   falls = 0;
    logic prev = 1'b1;
    for (int i = 0; i < FRAME && m_t != 5; i++) begin
      cyc(); checks++; if (outs !== e) begin errors++; $display("FAIL dbl_model: got %h want %h", outs, e); end
    end
    i_seg = {DIGITS{7'h7F}}; i_dp = '1; i_load = 1'b1;
    cyc(); i_load = 1'b0;
    checks++; if (outs !== e) begin errors++; $display("FAIL dbl_model: got %h want %h", outs, e); end
    cyc();
    checks++; if (outs !== e) begin errors++; $display("FAIL dbl_model: got %h want %h", outs, e); end
    for (int k = 0; k < DIGITS; k++) i_seg[7*k +: 7] = dec[(k + 1) % DIGITS];
    i_dp = 6'b100000; i_load = 1'b1;
    cyc(); i_load = 1'b0;
    checks++; if (outs !== e) begin errors++; $display("FAIL dbl_model: got %h want %h", outs, e); end
    repeat (2 * FRAME) begin
      cyc();
      checks++; if (outs !== e) begin errors++; $display("FAIL dbl_model: got %h want %h", outs, e); end
      checks++; if (o_seg === 7'h7F) begin errors++; $display("FAIL dbl_stale: seg %h must never be 7f", o_seg); end
      if (prev === 1'b1 && o_busy === 1'b0) falls++;
      prev = o_busy;
    end
    checks++; if (falls != 1) begin errors++; $display("FAIL dbl_busy_falls: got %0d want 1", falls); end
  endtask

  task automatic test_load_on_boundary();
    for (int i = 0; i < FRAME && m_t != 10; i++) begin
      cyc(); checks++; if (outs !== e) begin errors++; $display("FAIL bnd_model: got %h want %h", outs, e); end
    end
    i_seg = {DIGITS{7'h01}}; i_dp = '0; i_blank = '0; i_load = 1'b1;
    cyc(); i_load = 1'b0;
    checks++; if (outs !== e) begin errors++; $display("FAIL bnd_model: got %h want %h", outs, e); end
    for (int i = 0; i < FRAME && m_t != FRAME - 1; i++) begin
      cyc(); checks++; if (outs !== e) begin errors++; $display("FAIL bnd_model: got %h want %h", outs, e); end
    end
    i_seg = {DIGITS{7'h40}}; i_load = 1'b1;
    cyc(); i_load = 1'b0;
    checks++; if (outs !== e) begin errors++; $display("FAIL bnd_model: got %h want %h", outs, e); end
    checks++;
    if (o_frame !== 1'b1 || o_busy !== 1'b1) begin
      errors++; $display("FAIL bnd_busy_hold: frame %b busy %b want 1 1", o_frame, o_busy);
    end
    for (int n = 1; n <= FRAME; n++) begin
      cyc();
      checks++; if (outs !== e) begin errors++; $display("FAIL bnd_model: got %h want %h", outs, e); end
      checks++; if (o_seg !== 7'h01) begin errors++; $display("FAIL bnd_old_data: seg %h want 01", o_seg); end
      if (n == FRAME) begin
        checks++;
        if (o_frame !== 1'b1 || o_busy !== 1'b0) begin
          errors++; $display("FAIL bnd_busy_fall: frame %b busy %b want 1 0", o_frame, o_busy);
        end
      end
    end
    repeat (FRAME) begin
      cyc();
      checks++; if (outs !== e) begin errors++; $display("FAIL bnd_model: got %h want %h", outs, e); end
      checks++; if (o_seg !== 7'h40) begin errors++; $display("FAIL bnd_new_data: seg %h want 40", o_seg); end
    end
  endtask

  task automatic test_blank();
    int  lit = 0;
    bit  fell = 0;
    i_seg = {DIGITS{7'h7F}}; i_dp = '1; i_blank = 6'b100001; i_load = 1'b1;
    cyc(); i_load = 1'b0;
    checks++; if (outs !== e) begin errors++; $display("FAIL blank_model: got %h want %h", outs, e); end
    for (int i = 0; i < FRAME + 2 && !fell; i++) begin
      cyc();
      checks++; if (outs !== e) begin errors++; $display("FAIL blank_model: got %h want %h", outs, e); end
      if (o_busy === 1'b0) fell = 1;
    end
    checks++; if (!fell) begin errors++; $display("FAIL blank_timeout: busy %b want 0", o_busy); end
    repeat (FRAME) begin
      cyc();
      checks++; if (outs !== e) begin errors++; $display("FAIL blank_model: got %h want %h", outs, e); end
      checks++;
      if (o_seg_enb[0] !== 1'b1 || o_seg_enb[5] !== 1'b1 ||
          (o_seg_enb === '1 && (o_seg !== 7'd0 || o_seg_dp !== 1'b0))) begin
        errors++; $display("FAIL blank_slot: enb %b seg %h dp %b", o_seg_enb, o_seg, o_seg_dp);
      end
      if (o_seg_enb !== '1) lit++;
    end
    checks++; if (lit != 4 * SD) begin errors++; $display("FAIL blank_lit_cycles: got %0d want %0d", lit, 4 * SD); end
  endtask

  task automatic test_reset_mid();
    i_seg = {DIGITS{7'h7F}}; i_blank = '0; i_load = 1'b1;
    cyc(); i_load = 1'b0;
    checks++; if (outs !== e) begin errors++; $display("FAIL rmid_model: got %h want %h", outs, e); end
    for (int i = 0; i < SD && (m_t % SD) != 7; i++) begin
      cyc(); checks++; if (outs !== e) begin errors++; $display("FAIL rmid_model: got %h want %h", outs, e); end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_seg_enb !== '1 || o_seg !== 7'd0 || o_seg_dp !== 1'b0 || o_busy !== 1'b0 || o_frame !== 1'b0) begin
      errors++; $display("FAIL rmid_async: enb %b seg %h dp %b busy %b frame %b", o_seg_enb, o_seg, o_seg_dp, o_busy, o_frame);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if (outs !== e) begin errors++; $display("FAIL rmid_model: got %h want %h", outs, e); end
    checks++;
    if (o_seg_enb !== 6'b111110 || o_seg !== 7'd0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rmid_restart: enb %b seg %h busy %b want 111110 00 0", o_seg_enb, o_seg, o_busy);
    end
    repeat (FRAME) begin
      cyc();
      checks++; if (outs !== e) begin errors++; $display("FAIL rmid_model: got %h want %h", outs, e); end
      checks++; if (o_busy !== 1'b0 || o_seg !== 7'd0) begin errors++; $display("FAIL rmid_discard: busy %b seg %h", o_busy, o_seg); end
    end
  endtask

`ifdef FND_SCAN_BRIGHT_EN
  task automatic test_bright();
    int  lit;
    bit  seen = 0;
    i_bright = 4'd3;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      cyc(); checks++; if (outs !== e) begin errors++; $display("FAIL bright_model: got %h want %h", outs, e); end
      if (o_frame === 1'b1) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bright_timeout: no frame pulse"); end
    for (int pass = 0; pass < 2; pass++) begin
      lit = 0;
      repeat (FRAME) begin
        cyc(); checks++; if (outs !== e) begin errors++; $display("FAIL bright_model: got %h want %h", outs, e); end
        if (o_seg_enb !== '1) lit++;
      end
      checks++;
      if (lit != (pass == 0 ? 4 * DIGITS : 16 * DIGITS)) begin
        errors++; $display("FAIL bright_duty%0d: got %0d want %0d", pass, lit, pass == 0 ? 4 * DIGITS : 16 * DIGITS);
      end
      i_bright = 4'd15;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_double_load();
    test_load_on_boundary();
    test_blank();
    test_reset_mid();
`ifdef FND_SCAN_BRIGHT_EN
    test_bright();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
